// File: rtl/pattern_scan_engine_if.sv
// Data-memory port shared by the pattern scan engine and the memory it reads and writes.
// Read data is combinational: valid in the same cycle as mem_addr.
interface pattern_scan_engine_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/pattern_scan_engine.sv
// Pattern-search coprocessor: counts 5-bit pattern hits inside each message byte, bytes
// containing a hit, and hits across the whole bit string, then writes the three counts back.
module pattern_scan_engine #(
  parameter int MSG_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33,
  parameter int AW        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  pattern_scan_engine_if.master mem
);

  localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_PAT,
    SCAN,
    WR0,
    WR1,
    WR2,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [4:0]    pat_reg, pat_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [3:0]    tail_reg, tail_next;
  logic [7:0]    ctb_reg, ctb_next;
  logic [7:0]    cto_reg, cto_next;
  logic [7:0]    cts_reg, cts_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic          mem_wr_en_reg, mem_wr_en_next;
  logic [7:0]    mem_wr_data_reg, mem_wr_data_next;
  logic          done_reg, done_next;

  // Windows 0..3 lie wholly inside the current byte; 4..7 straddle the previous byte's low nibble.
  logic [11:0] win_word;
  logic [7:0]  win_match;
  logic [3:0]  pop_byte;
  logic [3:0]  pop_all;

  assign win_word = {tail_reg, mem.mem_rd_data};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_win
      assign win_match[gi] = (win_word[gi+4:gi] == pat_reg);
    end
  endgenerate

  always_comb begin
    pop_byte = '0;
    pop_all  = '0;
    for (int k = 0; k < 8; k++) begin
      pop_all = pop_all + 4'(win_match[k]);
      if (k < 4) begin
        pop_byte = pop_byte + 4'(win_match[k]);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    pat_next         = pat_reg;
    idx_next         = idx_reg;
    tail_next        = tail_reg;
    ctb_next         = ctb_reg;
    cto_next         = cto_reg;
    cts_next         = cts_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wr_en_next   = 1'b0;
    mem_wr_data_next = mem_wr_data_reg;
    done_next        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = LD_PAT;
          idx_next      = '0;
          tail_next     = '0;
          ctb_next      = '0;
          cto_next      = '0;
          cts_next      = '0;
          mem_addr_next = AW'(PAT_ADDR);
        end
      end

      LD_PAT: begin
        pat_next      = mem.mem_rd_data[7:3];
        state_next    = SCAN;
        mem_addr_next = '0;
      end

      SCAN: begin
        ctb_next  = ctb_reg + 8'(pop_byte);
        cto_next  = cto_reg + 8'(|win_match[3:0]);
        // The first byte has no predecessor, so its straddling windows are not real.
        cts_next  = cts_reg + ((idx_reg == '0) ? 8'(pop_byte) : 8'(pop_all));
        tail_next = mem.mem_rd_data[3:0];
        if (idx_reg == LAST_IDX) begin
          state_next       = WR0;
          mem_addr_next    = AW'(RES_ADDR);
          mem_wr_en_next   = 1'b1;
          mem_wr_data_next = ctb_next;
        end else begin
          idx_next      = idx_reg + 1'b1;
          mem_addr_next = AW'(idx_next);
        end
      end

      WR0: begin
        state_next       = WR1;
        mem_addr_next    = AW'(RES_ADDR + 1);
        mem_wr_en_next   = 1'b1;
        mem_wr_data_next = cto_reg;
      end

      WR1: begin
        state_next       = WR2;
        mem_addr_next    = AW'(RES_ADDR + 2);
        mem_wr_en_next   = 1'b1;
        mem_wr_data_next = cts_reg;
      end

      WR2: begin
        state_next = DONE;
      end

      DONE: begin
        if (start) begin
          state_next    = LD_PAT;
          idx_next      = '0;
          tail_next     = '0;
          ctb_next      = '0;
          cto_next      = '0;
          cts_next      = '0;
          mem_addr_next = AW'(PAT_ADDR);
        end else begin
          done_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      pat_reg         <= '0;
      idx_reg         <= '0;
      tail_reg        <= '0;
      ctb_reg         <= '0;
      cto_reg         <= '0;
      cts_reg         <= '0;
      mem_addr_reg    <= '0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_data_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pat_reg         <= pat_next;
      idx_reg         <= idx_next;
      tail_reg        <= tail_next;
      ctb_reg         <= ctb_next;
      cto_reg         <= cto_next;
      cts_reg         <= cts_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wr_en_reg   <= mem_wr_en_next;
      mem_wr_data_reg <= mem_wr_data_next;
      done_reg        <= done_next;
    end
  end

  assign mem.mem_addr    = mem_addr_reg;
  assign mem.mem_wr_en   = mem_wr_en_reg;
  assign mem.mem_wr_data = mem_wr_data_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Directed bench for pattern_scan_engine: behavioural data memory, hand-computed counts,
// latency and write-strobe accounting per run.
module tb_pattern_scan_engine;

  logic clk;
  logic reset;
  logic start;
  logic done;

  int checks;
  int failures;

  logic [7:0] msg_mem [0:63];
  logic [7:0] res_mem [0:2];
  int         write_count;
  int         bad_writes;
  logic [7:0] wr_off;

  pattern_scan_engine_if #(.AW(8)) mem_bus ();

  pattern_scan_engine dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_bus.mem_rd_data = (mem_bus.mem_addr <= 8'd32) ? msg_mem[mem_bus.mem_addr[5:0]] : 8'h00;
  assign wr_off = mem_bus.mem_addr - 8'd33;

  initial begin
    write_count = 0;
    bad_writes  = 0;
    for (int i = 0; i < 3; i++) res_mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_bus.mem_wr_en) begin
      write_count <= write_count + 1;
      if (mem_bus.mem_addr >= 8'd33 && mem_bus.mem_addr <= 8'd35)
        res_mem[wr_off[1:0]] <= mem_bus.mem_wr_data;
      else
        bad_writes <= bad_writes + 1;
    end
  end

  task automatic load_msg(input logic [7:0] fill, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] pat);
    for (int i = 0; i < 64; i++) msg_mem[i] = fill;
    msg_mem[0]  = b0;
    msg_mem[1]  = b1;
    msg_mem[32] = pat;
  endtask

  // Called just after a rising edge; start is sampled at the next edge (edge k).
  task automatic start_and_wait(output int lat);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || mem_bus.mem_addr !== 8'd0 || mem_bus.mem_wr_en !== 1'b0 ||
        mem_bus.mem_wr_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: done=%b addr=%0d wr_en=%b wr_data=%0d required 0/0/0/0",
               done, mem_bus.mem_addr, mem_bus.mem_wr_en, mem_bus.mem_wr_data);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL idle_done: got %b required 0", done);
    end
    $display("test_reset done");
  endtask

  task automatic test_pattern(input string name, input logic [7:0] fill, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] pat,
                              input logic [7:0] e_ctb, input logic [7:0] e_cto,
                              input logic [7:0] e_cts);
    int lat;
    int w0;
    load_msg(fill, b0, b1, pat);
    w0 = write_count;
    start_and_wait(lat);
    checks++;
    if (lat !== 37) begin
      failures++;
      $display("FAIL %s latency: got %0d required 37", name, lat);
    end
    checks++;
    if (write_count - w0 !== 3) begin
      failures++;
      $display("FAIL %s write_count: got %0d required 3", name, write_count - w0);
    end
    checks++;
    if (res_mem[0] !== e_ctb || res_mem[1] !== e_cto || res_mem[2] !== e_cts) begin
      failures++;
      $display("FAIL %s results: got %0d/%0d/%0d required %0d/%0d/%0d", name,
               res_mem[0], res_mem[1], res_mem[2], e_ctb, e_cto, e_cts);
    end
    $display("%s: lat=%0d ctb=%0d cto=%0d cts=%0d", name, lat, res_mem[0], res_mem[1], res_mem[2]);
  endtask

  task automatic test_restart_ignored();
    int lat;
    int w0;
    load_msg(8'h55, 8'h55, 8'h55, 8'hA8);
    w0 = write_count;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      start = (i == 10);
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat !== 37) begin
      failures++;
      $display("FAIL restart_latency: got %0d required 37", lat);
    end
    checks++;
    if (write_count - w0 !== 3) begin
      failures++;
      $display("FAIL restart_writes: got %0d required 3", write_count - w0);
    end
    checks++;
    if (res_mem[0] !== 8'd64 || res_mem[1] !== 8'd32 || res_mem[2] !== 8'd126) begin
      failures++;
      $display("FAIL restart_results: got %0d/%0d/%0d required 64/32/126",
               res_mem[0], res_mem[1], res_mem[2]);
    end
    $display("restart_ignored: lat=%0d writes=%0d", lat, write_count - w0);
  endtask

  task automatic test_reset_abort();
    int w0;
    load_msg(8'h55, 8'h55, 8'h55, 8'hA8);
    w0 = write_count;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    checks++;
    if (done !== 1'b0 || mem_bus.mem_wr_en !== 1'b0 || mem_bus.mem_addr !== 8'd0) begin
      failures++;
      $display("FAIL abort_outputs: done=%b wr_en=%b addr=%0d required 0/0/0",
               done, mem_bus.mem_wr_en, mem_bus.mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (write_count - w0 !== 0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_write: writes=%0d done=%b required 0/0", write_count - w0, done);
    end
    $display("reset_abort: writes=%0d done=%b", write_count - w0, done);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < 64; i++) msg_mem[i] = 8'h00;
    test_reset();
    test_pattern("run1_alt", 8'h55, 8'h55, 8'h55, 8'hA8, 8'd64, 8'd32, 8'd126);
    test_pattern("run2_zero", 8'h00, 8'h00, 8'h00, 8'h00, 8'd128, 8'd32, 8'd252);
    test_restart_ignored();
    test_pattern("run3_none", 8'h00, 8'h00, 8'h00, 8'hF8, 8'd0, 8'd0, 8'd0);
    test_pattern("pat_low_bits", 8'h55, 8'h55, 8'h55, 8'hAF, 8'd64, 8'd32, 8'd126);
    test_pattern("run4_cross", 8'h00, 8'h07, 8'hC0, 8'hF8, 8'd0, 8'd0, 8'd1);
    test_reset_abort();
    test_pattern("run5_rerun", 8'h55, 8'h55, 8'h55, 8'hA8, 8'd64, 8'd32, 8'd126);
    checks++;
    if (bad_writes !== 0) begin
      failures++;
      $display("FAIL write_address: got %0d stray writes required 0", bad_writes);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
